arrayadd_seq: RTL and testbench

ARRAYADD_SEQ -- requirements
Module: arrayadd_seq

---
 rtl/arrayadd_if.sv | 24 ++
 rtl/arrayadd_seq.sv | 111 +++++++++++
 tb/tb_arrayadd_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/arrayadd_if.sv
// Memory read port and result write port shared by the array adder and its memories.
// The master side issues reads and writes; the slave side returns read data one cycle later.
interface arrayadd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;

    modport master (
        output mem_rd_en, mem_addr, res_wr_en, res_addr, res_data,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  mem_rd_en, mem_addr, res_wr_en, res_addr, res_data,
        output rd_data_a, rd_data_b
    );
endinterface

// File: rtl/arrayadd_seq.sv
// Sequential element-wise adder: reads A[i] and B[i], writes A[i]+B[i] back at the same
// address one cycle later, and keeps a running total with a sticky carry-out flag.
module arrayadd_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              run,
    arrayadd_if.master        bus,
    output logic [DATA_W-1:0] total,
    output logic              ovf,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   cnt_p0;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W:0]   elem_sum_p1;
    logic [DATA_W:0]   acc_sum_p1;

    // Unsigned add that keeps the carry-out in the extra top bit.
    function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always_comb begin
        state_nxt = state;
        vld_p0    = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? FIN : ISSUE;
            ISSUE: if (run) begin
                vld_p0 = 1'b1;
                if (cnt_p0 == len_r - CNT_ONE) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0: read issue
    assign addr_p0       = base_r + cnt_p0[ADDR_W-1:0];
    assign bus.mem_rd_en = vld_p0;
    assign bus.mem_addr  = vld_p0 ? addr_p0 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_r <= '0;
            len_r  <= '0;
            cnt_p0 <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                base_r <= base;
                len_r  <= len;
                cnt_p0 <= '0;
            end else if (vld_p0) begin
                cnt_p0 <= cnt_p0 + CNT_ONE;
            end
        end
    end

    // Stage 1: read data returns, result write and accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) addr_p1 <= addr_p0;
        end
    end

    assign elem_sum_p1 = add_carry(bus.rd_data_a, bus.rd_data_b);
    assign acc_sum_p1  = add_carry(total, elem_sum_p1[DATA_W-1:0]);

    assign bus.res_wr_en = vld_p1;
    assign bus.res_addr  = vld_p1 ? addr_p1 : '0;
    assign bus.res_data  = vld_p1 ? elem_sum_p1[DATA_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            total <= '0;
            ovf   <= 1'b0;
        end else if (vld_p1) begin
            total <= acc_sum_p1[DATA_W-1:0];
            ovf   <= ovf | elem_sum_p1[DATA_W] | acc_sum_p1[DATA_W];
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);
endmodule

// File: tb/tb_arrayadd_seq.sv
// Randomized scoreboard bench for arrayadd_seq: a job-level model predicts every write,
// the final total/ovf and the done cycle; a negedge monitor pops and compares.
module tb_arrayadd_seq;
    localparam int     AW = 8;
    localparam int     DW = 32;
    localparam int     NA = 1 << AW;
    localparam longint M  = 64'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          run = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] total;
    logic          ovf, busy, done;

    arrayadd_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    arrayadd_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len), .run(run),
        .bus(bus), .total(total), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [NA];
    logic [DW-1:0] mem_b [NA];

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.rd_data_a <= mem_a[bus.mem_addr];
            bus.rd_data_b <= mem_b[bus.mem_addr];
        end
    end

    typedef struct { int addr; longint data; int cyc; } wr_t;
    typedef struct { longint tot; bit ovf; int cyc; } job_t;
    wr_t  wq[$];
    job_t jq[$];
    wr_t  w_m;
    job_t j_m;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     job_cyc0 = 0;
    bit     runpat [1024];
    int     exp_done;
    longint exp_tot;
    bit     exp_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.res_wr_en) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                w_m = wq.pop_front();
                chk("wr_addr", bus.res_addr, w_m.addr);
                chk("wr_data", bus.res_data, w_m.data);
                chk("wr_cycle", cyc - job_cyc0 + 1, w_m.cyc);
            end
        end
        if (done) begin
            if (jq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                j_m = jq.pop_front();
                chk("done_total", total, j_m.tot);
                chk("done_ovf", ovf, j_m.ovf);
                chk("done_cycle", cyc - job_cyc0 + 1, j_m.cyc);
                chk("writes_at_done", wq.size(), 0);
            end
        end
        if (!busy) chk("idle_strobes", {bus.mem_rd_en, bus.res_wr_en, done}, 0);
    end

    task automatic fill_run(input bit random_run);
        for (int k = 0; k < 1024; k++)
            runpat[k] = (!random_run || k >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    // Job model: reads happen on cycles where run is high, each write one cycle later.
    task automatic model_job(input int b, input int n);
        longint t = 0;
        longint s;
        bit     o = 0;
        int     issued = 0;
        int     k = 1;
        int     last = 0;
        int     a;
        while (issued < n) begin
            if (runpat[k]) begin
                a = (b + issued) % NA;
                s = longint'(mem_a[a]) + longint'(mem_b[a]);
                if (s >= M) begin o = 1; s = s - M; end
                t = t + s;
                if (t >= M) begin o = 1; t = t - M; end
                wq.push_back('{a, s, k + 1});
                issued++;
                last = k;
            end
            k++;
        end
        exp_done = (n == 0) ? 1 : last + 2;
        exp_tot  = t;
        exp_ovf  = o;
        jq.push_back('{t, o, exp_done});
    endtask

    task automatic run_job(input int b, input int n, input bit mid_start);
        int t = 0;
        model_job(b, n);
        base  = AW'(b);
        len   = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        job_cyc0 = cyc + 1;
        for (int k = 1; k <= exp_done; k++) begin
            run = runpat[k];
            if (mid_start && k == 3) begin
                start = 1'b1;
                len   = 8;
                base  = AW'($urandom);
            end else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        run   = 1'b1;
        while (busy && t < 50) begin @(posedge clk); #1; t++; end
        chk("job_returns_idle", busy, 0);
        chk("total_hold", total, exp_tot);
        chk("ovf_hold", ovf, exp_ovf);
        chk("jobs_left", jq.size(), 0);
        chk("writes_left", wq.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl", {bus.mem_rd_en, bus.res_wr_en, ovf, busy, done, bus.mem_addr, bus.res_addr}, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_total", total, 0);
    endtask

    initial begin
        for (int i = 0; i < NA; i++) begin
            mem_a[i] = DW'(i);
            mem_b[i] = DW'(2 * i);
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;

        // Basic job
        fill_run(0);
        run_job(0, 4, 0);
        chk("basic_total", total, 18);
        chk("basic_ovf", ovf, 0);

        // Address wrap and overflow
        mem_a[255] = 32'hFFFF_FFFF; mem_b[255] = 1;
        mem_a[0]   = 0;             mem_b[0]   = 0;
        run_job(255, 2, 0);
        chk("wrap_total", total, 0);
        chk("wrap_ovf", ovf, 1);

        // Stall on cycle 2 only
        fill_run(0);
        runpat[2] = 1'b0;
        run_job(0, 3, 0);

        // Zero length, then a start pulsed mid-job
        fill_run(0);
        run_job(5, 0, 0);
        run_job(10, 4, 1);

        // Reset mid-job, then restart straight after release
        fill_run(0);
        model_job(0, 16);
        base = 0; len = 16; start = 1'b1; run = 1'b1;
        @(posedge clk); #1;
        job_cyc0 = cyc + 1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        wq.delete();
        jq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_job(3, 5, 0);

        // Full range
        run_job(128, 256, 0);

        // Randomized jobs
        for (int i = 0; i < NA; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        for (int j = 0; j < 30; j++) begin
            int n;
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = 1;
                2:       n = 256;
                default: n = $urandom_range(2, 40);
            endcase
            fill_run(1);
            run_job($urandom_range(0, NA - 1), n, (n >= 2) && ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end
endmodule
